// File: rtl/gen_fifo_if.sv
// Handshake bundle between the sample generator, the FIFO and its read-side consumer.
// err_cnt_o is present only when FIFO_ERR_CNT_EN is defined.
interface gen_fifo_if #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16
);
  logic                          wr_en_i;
  logic signed [DATA_WIDTH-1:0]  data_i;
  logic                          rd_en_i;
  logic                          clr_err_i;
  logic signed [DATA_WIDTH-1:0]  data_o;
  logic                          rd_valid_o;
  logic                          empty_o;
  logic                          full_o;
  logic                          afull_o;
  logic [$clog2(DEPTH):0]        count_o;
  logic                          ovf_o;
  logic                          udf_o;
`ifdef FIFO_ERR_CNT_EN
  logic [7:0]                    err_cnt_o;
`endif

  modport slave (
    input  wr_en_i, data_i, rd_en_i, clr_err_i,
    output data_o, rd_valid_o, empty_o, full_o, afull_o, count_o, ovf_o, udf_o
`ifdef FIFO_ERR_CNT_EN
    , err_cnt_o
`endif
  );

  modport master (
    output wr_en_i, data_i, rd_en_i, clr_err_i,
    input  data_o, rd_valid_o, empty_o, full_o, afull_o, count_o, ovf_o, udf_o
`ifdef FIFO_ERR_CNT_EN
    , err_cnt_o
`endif
  );
endinterface

// File: rtl/gen_fifo.sv
// Synchronous sample FIFO behind funct_generator with sticky overflow/underflow flags.
// Define FIFO_ERR_CNT_EN to add the saturating 8-bit error event counter err_cnt_o.
module gen_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = 12
) (
  input  logic        clk,
  input  logic        rst,
  gen_fifo_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic signed [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]                wptr;
  logic [AW-1:0]                rptr;
  logic [CW-1:0]                count;
  logic signed [DATA_WIDTH-1:0] data_p1;
  logic                         vld_p1;
  logic                         ovf;
  logic                         udf;

  logic is_empty;
  logic is_full;
  logic rd_acc;
  logic wr_acc;
  logic wr_drop;
  logic rd_rej;

  assign is_empty = (count == '0);
  assign is_full  = (count == CW'(DEPTH));

  // A read frees a slot this cycle, so a full FIFO can still take a write alongside it.
  assign rd_acc  = bus.rd_en_i && !is_empty;
  assign wr_acc  = bus.wr_en_i && (!is_full || rd_acc);
  assign wr_drop = bus.wr_en_i && !wr_acc;
  assign rd_rej  = bus.rd_en_i && is_empty;

  // Storage is data only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr] <= bus.data_i;
  end

  // Stage p1: pointers, occupancy, registered read data and its valid pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      ovf     <= 1'b0;
      udf     <= 1'b0;
    end else begin
      vld_p1 <= rd_acc;
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) begin
        rptr    <= rptr + 1'b1;
        data_p1 <= mem[rptr];
      end
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
      if (wr_drop)            ovf <= 1'b1;
      else if (bus.clr_err_i) ovf <= 1'b0;
      if (rd_rej)             udf <= 1'b1;
      else if (bus.clr_err_i) udf <= 1'b0;
    end
  end

  assign bus.data_o     = data_p1;
  assign bus.rd_valid_o = vld_p1;
  assign bus.count_o    = count;
  assign bus.empty_o    = is_empty;
  assign bus.full_o     = is_full;
  assign bus.afull_o    = (count >= CW'(AFULL_TH));
  assign bus.ovf_o      = ovf;
  assign bus.udf_o      = udf;

`ifdef FIFO_ERR_CNT_EN
  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] inc);
    logic [8:0] s;
    s = {1'b0, a} + {7'b0, inc};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  logic [7:0] err_cnt;
  logic [7:0] err_base;
  logic [1:0] err_inc;

  // Clear first, then add this cycle's events, so a coincident error counts from zero.
  assign err_base = bus.clr_err_i ? 8'd0 : err_cnt;
  assign err_inc  = {1'b0, wr_drop} + {1'b0, rd_rej};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_cnt <= 8'd0;
    else      err_cnt <= sat_add8(err_base, err_inc);
  end

  assign bus.err_cnt_o = err_cnt;
`endif
endmodule

// File: tb/tb_gen_fifo.sv
// Self-checking bench for gen_fifo: directed table, hand sequences and random traffic
// compared against a queue-based reference model.
module tb_gen_fifo;
  localparam int DW  = 16;
  localparam int DEP = 16;
  localparam int ATH = 12;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gen_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEP)) bus ();
  gen_fifo #(.DATA_WIDTH(DW), .DEPTH(DEP), .AFULL_TH(ATH)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int q[$];
  int m_data;
  bit m_vld;
  bit m_ovf;
  bit m_udf;
  int m_err;

  typedef struct {
    bit wr; int din; bit rd; bit clr;
    int e_data; bit e_vld; int e_cnt; bit e_empty; bit e_udf;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_data = 0; m_vld = 0; m_ovf = 0; m_udf = 0; m_err = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".data"},  int'(bus.data_o), m_data);
    chk({tag, ".vld"},   int'(bus.rd_valid_o), int'(m_vld));
    chk({tag, ".count"}, int'(bus.count_o), q.size());
    chk({tag, ".empty"}, int'(bus.empty_o), int'(q.size() == 0));
    chk({tag, ".full"},  int'(bus.full_o), int'(q.size() == DEP));
    chk({tag, ".afull"}, int'(bus.afull_o), int'(q.size() >= ATH));
    chk({tag, ".ovf"},   int'(bus.ovf_o), int'(m_ovf));
    chk({tag, ".udf"},   int'(bus.udf_o), int'(m_udf));
`ifdef FIFO_ERR_CNT_EN
    chk({tag, ".errcnt"}, int'(bus.err_cnt_o), m_err);
`endif
  endtask

  // Drive one cycle, advance the model, compare after the edge.
  task automatic step(input bit wr, input int d, input bit rd, input bit clr, input string tag);
    bit rd_ok, wr_ok, drop, rej;
    int din;
    logic [DW-1:0] dv;
    dv = d[DW-1:0];
    din = int'($signed(dv));
    bus.wr_en_i = wr; bus.data_i = dv; bus.rd_en_i = rd; bus.clr_err_i = clr;
    rd_ok = rd && (q.size() > 0);
    wr_ok = wr && ((q.size() < DEP) || rd_ok);
    drop  = wr && !wr_ok;
    rej   = rd && (q.size() == 0);
    m_vld = rd_ok;
    if (rd_ok) m_data = q.pop_front();
    if (wr_ok) q.push_back(din);
    if (drop) m_ovf = 1; else if (clr) m_ovf = 0;
    if (rej)  m_udf = 1; else if (clr) m_udf = 0;
    if (clr) m_err = 0;
    m_err = m_err + int'(drop) + int'(rej);
    if (m_err > 255) m_err = 255;
    @(posedge clk);
    #1;
    check_model(tag);
    bus.wr_en_i = 0; bus.rd_en_i = 0; bus.clr_err_i = 0;
  endtask

  vec_t vt[10];

  initial begin
    checks = 0; failures = 0;
    bus.wr_en_i = 0; bus.data_i = '0; bus.rd_en_i = 0; bus.clr_err_i = 0;
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.count", int'(bus.count_o), 0);
    chk("reset.empty", int'(bus.empty_o), 1);
    chk("reset.full",  int'(bus.full_o), 0);
    chk("reset.afull", int'(bus.afull_o), 0);
    chk("reset.data",  int'(bus.data_o), 0);
    chk("reset.vld",   int'(bus.rd_valid_o), 0);
    chk("reset.ovf",   int'(bus.ovf_o), 0);
    chk("reset.udf",   int'(bus.udf_o), 0);
    rst_n = 1;

    // Directed table: three writes, three reads, underflow and clear corners
    vt[0] = '{1, -5,    0, 0, 0,     0, 1, 0, 0};
    vt[1] = '{1, 100,   0, 0, 0,     0, 2, 0, 0};
    vt[2] = '{1, 32767, 0, 0, 0,     0, 3, 0, 0};
    vt[3] = '{0, 0,     1, 0, -5,    1, 2, 0, 0};
    vt[4] = '{0, 0,     1, 0, 100,   1, 1, 0, 0};
    vt[5] = '{0, 0,     1, 0, 32767, 1, 0, 1, 0};
    vt[6] = '{0, 0,     1, 0, 32767, 0, 0, 1, 1};
    vt[7] = '{0, 0,     0, 1, 32767, 0, 0, 1, 0};
    vt[8] = '{1, 7,     1, 0, 32767, 0, 1, 0, 1};
    vt[9] = '{0, 0,     1, 1, 7,     1, 0, 1, 0};
    for (int i = 0; i < 10; i++) begin
      step(vt[i].wr, vt[i].din, vt[i].rd, vt[i].clr, $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.data", i),  int'(bus.data_o), vt[i].e_data);
      chk($sformatf("tbl%0d.vld", i),   int'(bus.rd_valid_o), int'(vt[i].e_vld));
      chk($sformatf("tbl%0d.count", i), int'(bus.count_o), vt[i].e_cnt);
      chk($sformatf("tbl%0d.empty", i), int'(bus.empty_o), int'(vt[i].e_empty));
      chk($sformatf("tbl%0d.udf", i),   int'(bus.udf_o), int'(vt[i].e_udf));
    end

    // Fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      step(1, i, 0, 0, "fill");
      chk($sformatf("fill%0d.afull", i + 1), int'(bus.afull_o), int'(i + 1 >= 12));
    end
    chk("fill.full", int'(bus.full_o), 1);
    chk("fill.count", int'(bus.count_o), 16);
    step(1, 32'h7FFF, 0, 0, "ovf");
    chk("ovf.flag", int'(bus.ovf_o), 1);
    chk("ovf.count", int'(bus.count_o), 16);
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, "drain");
      chk($sformatf("drain%0d.data", i), int'(bus.data_o), i);
    end
    step(0, 0, 0, 1, "clr1");
    chk("clr1.ovf", int'(bus.ovf_o), 0);

    // Full FIFO with simultaneous write and read
    for (int i = 0; i < 16; i++) step(1, 200 + i, 0, 0, "fill2");
    step(1, 32'h1234, 1, 0, "wr_rd_full");
    chk("wr_rd_full.data", int'(bus.data_o), 200);
    chk("wr_rd_full.count", int'(bus.count_o), 16);
    chk("wr_rd_full.ovf", int'(bus.ovf_o), 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, "drain2");
    chk("drain2.last", int'(bus.data_o), 32'h1234);
    chk("drain2.empty", int'(bus.empty_o), 1);

    // 40 write/read pairs with a sawtooth generator pattern, wrapping pointers twice
    for (int i = 0; i < 40; i++) begin
      step(1, (i * 1500) - 30000, 0, 0, "pair_wr");
      step(0, 0, 1, 0, "pair_rd");
      chk($sformatf("pair%0d.data", i), int'(bus.data_o), (i * 1500) - 30000);
    end

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 55), int'($urandom_range(0, 65535)) - 32768,
           ($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < 5), "rand");
    end

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) step(1, 1000 + i, (i > 2), 0, "pre_rst");
    #2;
    rst_n = 0;
    #1;
    chk("arst.count", int'(bus.count_o), 0);
    chk("arst.empty", int'(bus.empty_o), 1);
    chk("arst.data",  int'(bus.data_o), 0);
    chk("arst.vld",   int'(bus.rd_valid_o), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    step(0, 0, 0, 0, "post_rst");

`ifdef FIFO_ERR_CNT_EN
    for (int i = 0; i < 16; i++) step(1, i, 0, 0, "efill");
    for (int i = 0; i < 300; i++) step(1, 32'h7FFF, 0, 0, "edrop");
    chk("errcnt.sat", int'(bus.err_cnt_o), 255);
    step(0, 0, 0, 1, "eclr");
    chk("errcnt.clr", int'(bus.err_cnt_o), 0);
    step(1, 5, 0, 1, "eclr_hit");
    chk("errcnt.clr_hit", int'(bus.err_cnt_o), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/gen_fifo.md
Name: gen_fifo

Overview:
- Synchronous FIFO directly downstream of funct_generator.
- Absorbs the generator's write strobe and signed sample word (wr_en_o/data_o) and buffers the samples for a read-side consumer.
- Reports occupancy, full/empty/almost-full status and sticky overflow/underflow error flags.
- Single clock domain; no CDC.

Parameters:
- DATA_WIDTH, 16, sample width; matches the generator output width from fifo_defines_pkg.
- DEPTH, 16, number of entries; power of two, minimum 4.
- AFULL_TH, 12, occupancy at or above which afull_o asserts; range 1..DEPTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- wr_en_i  input  1  write strobe, driven by generator wr_en_o
- data_i  input  DATA_WIDTH  signed sample, driven by generator data_o
- rd_en_i  input  1  read request from consumer
- clr_err_i  input  1  synchronous clear of the sticky error flags
- data_o  output  DATA_WIDTH  signed read data, registered
- rd_valid_o  output  1  one-cycle pulse; data_o holds a newly popped word
- empty_o  output  1  occupancy == 0
- full_o  output  1  occupancy == DEPTH
- afull_o  output  1  occupancy >= AFULL_TH
- count_o  output  $clog2(DEPTH)+1  current occupancy
- ovf_o  output  1  sticky: a write was dropped
- udf_o  output  1  sticky: a read hit an empty FIFO
- err_cnt_o  output  8  error event counter; present only with FIFO_ERR_CNT_EN

Behaviour:
- Reset (rst low, asynchronous):
  - pointers and count = 0; data_o = 0; rd_valid_o = 0.
  - ovf_o = udf_o = 0; empty_o = 1; full_o = 0; afull_o = 0.
  - Memory contents are don't-care.
  - Reset mid-operation discards all stored data; outputs take reset values immediately.
- Storage: DEPTH x DATA_WIDTH register array. Write and read pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Write acceptance: accepted when wr_en_i=1 and (!full_o or read accepted in the same cycle). The accepted word goes to mem[wptr] and wptr increments.
- Read acceptance: accepted when rd_en_i=1 and !empty_o. On the next edge: data_o <= mem[rptr], rptr increments, rd_valid_o=1 for one cycle. Latency is 1 clock from rd_en_i to data.
- data_o holds its last value when no read is accepted.
- Count update per cycle: +1 (write only), -1 (read only), unchanged (both or neither).
- Status flags empty_o, full_o, afull_o and count_o are registered or derived from registered count; they are valid in the cycle after the causing edge.
- Boundary cases:
  - Full, write + read in the same cycle: both accepted; count stays DEPTH.
  - Full, write only: word dropped; ovf_o set at the next edge; memory and pointers unchanged.
  - Empty, read + write in the same cycle: read rejected and udf_o set; write accepted; count becomes 1.
  - Empty, read only: udf_o set; rd_valid_o stays 0; data_o unchanged.
- Error flags:
  - ovf_o and udf_o stay set until clr_err_i=1.
  - If clr_err_i coincides with a new error event, the error wins and the flag stays 1.
- Pointer wrap: after DEPTH accepted writes, wptr returns to 0; the ordering of stored data is preserved across the wrap.

Optional Feature:
- Macro: FIFO_ERR_CNT_EN.
- When defined:
  - err_cnt_o exists: an 8-bit counter incremented once per cycle in which a dropped write or a rejected read occurs.
  - If both occur in the same cycle, it increments by 2.
  - It saturates at 255 and clears on clr_err_i (an error in the same cycle wins, giving the increment from 0). Reset value 0.
- When undefined: err_cnt_o port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then 3 writes (data_i = -5, 100, 32767), then 3 reads -> data_o = -5, 100, 32767 on consecutive cycles, each with rd_valid_o=1; final empty_o=1, count_o=0.
- 16 writes of 0..15 with DEPTH=16 -> full_o=1, afull_o asserts after the 12th write, count_o=16. A 17th write (0x7FFF) -> ovf_o=1 and count stays 16. 16 reads return 0..15 in order.
- Full FIFO, simultaneous write(0x1234) + read -> oldest word output, count_o stays 16, ovf_o stays 0; after draining, 0x1234 is the last word out.
- Empty FIFO, rd_en_i=1 alone -> udf_o=1, rd_valid_o=0. Then clr_err_i=1 -> udf_o=0 on the next cycle.
- 40 write/read pairs alternating with the generator pattern -> pointers wrap twice with no data loss or reorder. Assert rst low mid-stream -> count_o=0, empty_o=1, data_o=0 asynchronously.
- With FIFO_ERR_CNT_EN: 300 dropped writes into a full FIFO -> err_cnt_o=255 (saturated); clr_err_i -> 0.
